fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Parametrised program-counter unit for the instruction-fetch stage; successor to the fixed 32-bit, free-running PC. Generates `ins_address` toward instruction memory under a valid/ready handshake, so the PC advances only when memory accepts. Supports branch, call and return redirects, a configurable end-of-program halt, and an optional return-address stack (RAS).

## Interface
- `ADDR_W`, 32: width of `ins_address`.
- `TGT_W`, 16: width of `branch_target`; zero-extended to `ADDR_W`. Must satisfy `TGT_W <= ADDR_W`.
- `STEP`, 4: byte increment per sequential fetch.
- `LAST_ADDR`, 32'h3FC: address of the last instruction; must be `STEP`-aligned.
- `RAS_DEPTH`, 4: RAS entries, a power of two ≥ 2. Used only with `FETCH_PC_RAS_EN`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `pc_ready` in 1: instruction memory accepts `ins_address` this cycle.
- `branch_en` in 1: redirect to `branch_target`.
- `call_en` in 1: redirect to `branch_target` and push the return address.
- `ret_en` in 1: redirect to the popped return address.
- `branch_target` in TGT_W: redirect target.
- `ins_address` out ADDR_W: current fetch address (registered).
- `pc_valid` out 1: `ins_address` is a valid fetch request.
- `halted` out 1: the PC has retired `LAST_ADDR` and is stopped.
- `ras_err` out 1: one-cycle pulse on RAS overflow or underflow.

## Operation
- **Fire:** `pc_valid && pc_ready` in the same cycle.
- **States:**
  - `BOOT`: `pc_valid`=0. Always moves to `RUN` on the next cycle.
  - `RUN`: `pc_valid`=1.
  - `HALT`: `pc_valid`=0, `halted`=1.
- **Next-PC priority** (evaluated every cycle; the first match wins):
  1. `reset` low.
  2. `branch_en`.
  3. `call_en`.
  4. `ret_en`.
  5. Sequential advance on fire.
  6. Hold.
- **Redirects** (`branch_en`, `call_en`, `ret_en`):
  - Take effect regardless of `pc_ready`; an unaccepted request is discarded.
  - Legal in every state. From `BOOT` or `HALT` they move the unit to `RUN`.
- **Sequential advance:** in `RUN`, on fire:
  - If `ins_address == LAST_ADDR`: move to `HALT` and hold `ins_address`.
  - Otherwise: `ins_address <= ins_address + STEP`, modulo 2^ADDR_W.
- **No fire** (`pc_ready` low in `RUN`): `ins_address` and `pc_valid` hold.
- **Call:**
  - Pushes `ins_address + STEP`, then loads the zero-extended target.
  - When the RAS is full, the oldest entry is overwritten (circular) and `ras_err` pulses.
- **Ret:**
  - Pops the top entry into `ins_address`.
  - When the RAS is empty: `ins_address` holds, the state does not change, and `ras_err` pulses.
- **Simultaneous strobes:**
  - A strobe of lower priority is dropped entirely, including its RAS side effect.
  - Example: `branch_en`+`call_en` performs the branch and leaves the RAS untouched.

## Timing
- **Reset values:**
  - `ins_address` = 0, `pc_valid` = 0, `halted` = 0, `ras_err` = 0.
  - RAS pointer and count = 0. State = `BOOT`.
- **Latency:**
  - The first valid request is the cycle after reset release.
  - A redirect asserted in cycle N makes `ins_address` equal the target in cycle N+1 with `pc_valid`=1.
- **Handshake:** `ins_address` is stable while `pc_valid && !pc_ready`, unless a redirect occurs.
- **`ras_err`:** asserted the cycle after the offending strobe, for exactly one cycle.
- **Reset mid-operation:** reset low in any state, including a pending unaccepted request, returns the unit to reset values on the next edge. The RAS is emptied.
- **`halted`:** asserted the cycle after the fire at `LAST_ADDR`; deasserted the cycle after a redirect.

## Configuration
- `FETCH_PC_RAS_EN` defined: RAS, `call_en` push and `ret_en` pop are built as described above.
- Not defined:
  - No RAS storage is built.
  - `call_en` behaves exactly like `branch_en`.
  - `ret_en` is ignored.
  - `ras_err` is tied to 0.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (`BOOT`, `RUN`, `HALT`);
  - defaults `FETCH_ADDR_W`, `FETCH_STEP`, `FETCH_LAST_ADDR`;
  - the next-PC select encoding.
- One sub-module, `ras_stack`:
  - Parameters: `DEPTH`, `WIDTH`. Circular push/pop with count.
  - Outputs: `empty`, `full`, `top`.
  - Instantiated only under `FETCH_PC_RAS_EN`.

## Test plan
- **Reset and run:** release reset with `pc_ready`=1.
  - `pc_valid` rises one cycle later; `ins_address` steps 0, 4, 8, …
- **Backpressure:** hold `pc_ready`=0 for 3 cycles at 0x10.
  - `ins_address` stays 0x10 with `pc_valid`=1; after release it proceeds to 0x14.
- **End of program:** run to 0x3FC with `pc_ready`=1.
  - `halted`=1 and `pc_valid`=0 the next cycle; `ins_address` stays 0x3FC.
  - Then `branch_en`, target 0x20: `ins_address`=0x20, `pc_valid`=1, `halted`=0.
- **Simultaneous strobes:** `branch_en`=1, target 0x40, and `call_en`=1 in the same cycle while `pc_ready`=0.
  - `ins_address`=0x40 the next cycle; the RAS count is unchanged.
- **RAS** (with `FETCH_PC_RAS_EN`):
  - Call from 0x8 to 0x100: `ins_address` becomes 0x100.
  - A following `ret_en`: `ins_address`=0xC.
  - A second `ret_en`: `ras_err` pulses and `ins_address` holds 0xC.
  - 5 calls with `RAS_DEPTH`=4: `ras_err` pulses on the 5th call.
- **Reset mid-run:** assert reset at 0x80 with `pc_ready`=0.
  - `ins_address`=0 and `pc_valid`=0 the next cycle; the RAS is empty.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage program-counter unit.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W    = 32;
  localparam int unsigned FETCH_TGT_W     = 16;
  localparam int unsigned FETCH_STEP      = 4;
  localparam logic [31:0] FETCH_LAST_ADDR = 32'h0000_03FC;
  localparam int unsigned FETCH_RAS_DEPTH = 4;

  // Fetch control state
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Next-PC source, listed in priority order
  typedef enum logic [2:0] {
    SEL_RESET  = 3'd0,
    SEL_BRANCH = 3'd1,
    SEL_CALL   = 3'd2,
    SEL_RET    = 3'd3,
    SEL_SEQ    = 3'd4,
    SEL_HOLD   = 3'd5
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign top   = mem[ptr - PTR_W'(1)];

  // Write pointer and occupancy; ptr always addresses the next free (or oldest) slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (reset && push) mem[ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with valid/ready handshake, redirects and end-of-program halt.
// Optional return-address stack built when FETCH_PC_RAS_EN is defined.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W    = FETCH_ADDR_W,
  parameter int unsigned        TGT_W     = FETCH_TGT_W,
  parameter int unsigned        STEP      = FETCH_STEP,
  parameter logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FETCH_LAST_ADDR),
  parameter int unsigned        RAS_DEPTH = FETCH_RAS_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_ready,
  input  logic              branch_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [TGT_W-1:0]  branch_target,
  output logic [ADDR_W-1:0] ins_address,
  output logic              pc_valid,
  output logic              halted,
  output logic              ras_err
);

  fetch_state_e      state, state_nxt;
  pc_sel_e           sel;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] tgt_ext;
  logic [ADDR_W-1:0] seq_addr;
  logic              fire_c;
  logic              err_nxt;
  logic              ras_push;
  logic              ras_pop;

  assign fire_c   = pc_valid && pc_ready;
  assign tgt_ext  = ADDR_W'(branch_target);
  assign seq_addr = ins_address + ADDR_W'(STEP);

`ifdef FETCH_PC_RAS_EN
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err_q;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Error pulse for the strobe seen on the previous edge
  always_ff @(posedge clk) begin
    if (!reset) ras_err_q <= 1'b0;
    else        ras_err_q <= err_nxt;
  end

  assign ras_err = ras_err_q;
`else
  logic                  ras_unused;
  localparam int unsigned RAS_UNUSED_DEPTH = RAS_DEPTH;

  assign ras_unused = ret_en | ras_push | ras_pop | err_nxt;
  assign ras_err    = 1'b0;
`endif

  // Next-PC source select, next state and next address
  always_comb begin
    sel       = SEL_HOLD;
    state_nxt = state;
    addr_nxt  = ins_address;
    err_nxt   = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;

    if (!reset)                    sel = SEL_RESET;
    else if (branch_en)            sel = SEL_BRANCH;
    else if (call_en)              sel = SEL_CALL;
`ifdef FETCH_PC_RAS_EN
    else if (ret_en)               sel = SEL_RET;
`endif
    else if (state == RUN && fire_c) sel = SEL_SEQ;

    // BOOT lasts a single cycle whatever else happens
    if (state == BOOT) state_nxt = RUN;

    unique case (sel)
      SEL_RESET: begin
        state_nxt = BOOT;
        addr_nxt  = '0;
      end
      SEL_BRANCH: begin
        state_nxt = RUN;
        addr_nxt  = tgt_ext;
      end
      SEL_CALL: begin
        state_nxt = RUN;
        addr_nxt  = tgt_ext;
`ifdef FETCH_PC_RAS_EN
        ras_push  = 1'b1;
        err_nxt   = ras_full;
`endif
      end
      SEL_RET: begin
`ifdef FETCH_PC_RAS_EN
        if (ras_empty) begin
          err_nxt = 1'b1;
        end else begin
          ras_pop   = 1'b1;
          state_nxt = RUN;
          addr_nxt  = ras_top;
        end
`endif
      end
      SEL_SEQ: begin
        if (ins_address == LAST_ADDR) state_nxt = HALT;
        else                          addr_nxt  = seq_addr;
      end
      default: ;
    endcase
  end

  // State, address and status registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= BOOT;
      ins_address <= '0;
      pc_valid    <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      ins_address <= addr_nxt;
      pc_valid    <= (state_nxt == RUN);
      halted      <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit; RAS sequences run when FETCH_PC_RAS_EN is defined.
module tb_fetch_pc_unit;

`ifdef FETCH_PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_ready;
  logic        branch_en;
  logic        call_en;
  logic        ret_en;
  logic [15:0] branch_target;
  logic [31:0] ins_address;
  logic        pc_valid;
  logic        halted;
  logic        ras_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pc_ready      (pc_ready),
    .branch_en     (branch_en),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .branch_target (branch_target),
    .ins_address   (ins_address),
    .pc_valid      (pc_valid),
    .halted        (halted),
    .ras_err       (ras_err)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic        cl;
    logic        rt;
    logic [15:0] tgt;
    logic [31:0] a;
    logic        v;
    logic        h;
    logic        e;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(logic rst, logic rdy, logic br, logic cl, logic rt,
                              logic [15:0] tgt, logic [31:0] a, logic v, logic h, logic e);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.br = br; r.cl = cl; r.rt = rt; r.tgt = tgt;
    r.a = a; r.v = v; r.h = h; r.e = e;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic br, input logic cl,
                       input logic rt, input logic [15:0] tgt);
    reset = rst; pc_ready = rdy; branch_en = br; call_en = cl; ret_en = rt;
    branch_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] a, input logic v,
                           input logic h, input logic e);
    check({tag, ".addr"},   ins_address, a);
    check({tag, ".valid"},  32'(pc_valid), 32'(v));
    check({tag, ".halted"}, 32'(halted), 32'(h));
    check({tag, ".ras_err"}, 32'(ras_err), 32'(e));
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
  endtask

  initial begin
    int cycles;

    vecs[0]  = mk(0, 1, 0, 0, 0, 16'h0000, 32'h0000_0000, 0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0000, 1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0004, 1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0008, 1, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_000C, 1, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0010, 1, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0000_0010, 1, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0000_0010, 1, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0000_0010, 1, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0014, 1, 0, 0);
    vecs[10] = mk(1, 0, 1, 0, 0, 16'h03F8, 32'h0000_03F8, 1, 0, 0);
    vecs[11] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_03FC, 1, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0000_03FC, 1, 0, 0);
    vecs[13] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_03FC, 0, 1, 0);
    vecs[14] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_03FC, 0, 1, 0);
    vecs[15] = mk(1, 1, 1, 0, 0, 16'h0020, 32'h0000_0020, 1, 0, 0);
    vecs[16] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0024, 1, 0, 0);
    vecs[17] = mk(1, 0, 1, 1, 0, 16'h0040, 32'h0000_0040, 1, 0, 0);
    vecs[18] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_0044, 1, 0, 0);
    vecs[19] = mk(1, 0, 0, 1, 0, 16'h0080, 32'h0000_0080, 1, 0, 0);
    vecs[20] = mk(0, 0, 0, 0, 0, 16'h0000, 32'h0000_0000, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0000_0000, 1, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0000_0000, 1, 0, 0);
    vecs[23] = mk(1, 0, 1, 0, 0, 16'hFFF8, 32'h0000_FFF8, 1, 0, 0);
    vecs[24] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0000_FFFC, 1, 0, 0);
    vecs[25] = mk(1, 1, 0, 0, 0, 16'h0000, 32'h0001_0000, 1, 0, 0);
    vecs[26] = mk(1, 0, 0, 0, 1, 16'h0000, 32'h0001_0000, 1, 0, RAS_ON);
    vecs[27] = mk(1, 0, 0, 0, 0, 16'h0000, 32'h0001_0000, 1, 0, 0);

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].br, vecs[i].cl, vecs[i].rt, vecs[i].tgt);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].v, vecs[i].h, vecs[i].e);
    end

    // Full run from reset to end of program: halted appears 257 edges after release
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    reset = 1'b1;
    cycles = 0;
    while (!halted && cycles < 400) begin
      step();
      cycles++;
    end
    check("run.cycles", 32'(cycles), 32'd257);
    check_all("run.end", 32'h3FC, 1'b0, 1'b1, 1'b0);

`ifdef FETCH_PC_RAS_EN
    // Call / return / underflow
    do_reset();
    pc_ready = 1'b1;
    step(); step();
    check("ras.at8", ins_address, 32'h8);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100);
    step();
    check_all("ras.call", 32'h100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0);
    step();
    check_all("ras.ret", 32'hC, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    step();
    check_all("ras.under", 32'hC, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    check_all("ras.under_end", 32'hC, 1'b1, 1'b0, 1'b0);

    // Branch beats call: the RAS stays empty
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0040);
    step();
    check("ras.brcall", ins_address, 32'h40);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    step();
    check_all("ras.brcall_empty", 32'h40, 1'b1, 1'b0, 1'b1);

    // Five calls into a four-deep stack; the oldest entry is lost
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'(k * 256));
      step();
      check_all($sformatf("ras.call%0d", k), 32'(k * 256), 1'b1, 1'b0, (k == 5));
    end
    for (int k = 4; k >= 1; k--) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
      step();
      check_all($sformatf("ras.pop%0d", k), 32'(k * 256 + 4), 1'b1, 1'b0, 1'b0);
    end
    step();
    check_all("ras.pop_empty", 32'h104, 1'b1, 1'b0, 1'b1);

    // Reset mid-run with a pending request empties the stack
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0080);
    step();
    check("ras.pre_rst", ins_address, 32'h80);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    check_all("ras.rst", 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
    step();
    check_all("ras.rst_empty", 32'h0, 1'b1, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
